mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_ctrl_decode.sv | 66 ++++++
 rtl/mips_multicycle_ctrl.sv | 120 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcodes, state encodings, mux-select codes and control vector for the
// multi-cycle MIPS main controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // pc_write is unconditional, pc_cond is qualified by the branch outcome
  typedef struct packed {
    logic       pc_write;
    logic       pc_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure Moore decode: current state -> raw control vector (no handshake gating).
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_B;
        o_ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUSRCB_B;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        o_ctrl.pc_cond   = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.pc_write  = 1'b1;
      end
      S_ADDI_WB: o_ctrl.reg_write = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with memory ready handshake and retire counter.
// Optional MIPS_CTRL_BNE_EN adds bne (opcode 000101) through the BRANCH state.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [5:0]         i_opcode,
  input  logic               i_alu_zero,
  input  logic               i_mem_ready,
  output logic               o_pc_en,
  output logic               o_i_or_d,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic               o_mem_to_reg,
  output logic               o_reg_dst,
  output logic               o_reg_write,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_alu_op,
  output logic [1:0]         o_pc_source,
  output logic               o_illegal_op,
  output logic [STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]   o_instr_cnt
);

  state_t           r_state, w_next, w_dec_state;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             r_illegal;
  logic             w_bad_op, w_retire, w_taken, w_gate;
  ctrl_t            w_ctrl;

  // Selects show FETCH values while reset is held, whatever r_state holds
  assign w_dec_state = i_rst_n ? r_state : S_FETCH;

  mips_ctrl_decode u_dec (
    .i_state (w_dec_state),
    .o_ctrl  (w_ctrl)
  );

`ifdef MIPS_CTRL_BNE_EN
  logic r_is_bne;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 r_is_bne <= 1'b0;
    else if (r_state == S_DECODE) r_is_bne <= (i_opcode == OP_BNE);
  end
  assign w_taken = r_is_bne ? ~i_alu_zero : i_alu_zero;
`else
  assign w_taken = i_alu_zero;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_FETCH;
      r_instr_cnt <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_illegal   <= w_bad_op;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next   = S_FETCH;
    w_bad_op = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       w_next = S_BRANCH;
`endif
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_bad_op = 1'b1;
        endcase
      end
      S_MEM_ADDR:  w_next = (i_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = i_mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        w_next   = i_mem_ready ? S_FETCH : S_MEM_WRITE;
        w_retire = i_mem_ready;
      end
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
      default:     w_next = S_FETCH;
    endcase
  end

  // In FETCH the IR load and PC increment wait for the instruction word
  always_comb begin
    w_gate       = (w_dec_state != S_FETCH) | i_mem_ready;
    o_pc_en      = i_rst_n & ((w_ctrl.pc_write & w_gate) | (w_ctrl.pc_cond & w_taken));
    o_ir_write   = i_rst_n & w_ctrl.ir_write & w_gate;
    o_mem_read   = i_rst_n & w_ctrl.mem_read;
    o_mem_write  = i_rst_n & w_ctrl.mem_write;
    o_reg_write  = i_rst_n & w_ctrl.reg_write;
    o_i_or_d     = w_ctrl.i_or_d;
    o_mem_to_reg = w_ctrl.mem_to_reg;
    o_reg_dst    = w_ctrl.reg_dst;
    o_alu_src_a  = w_ctrl.alu_src_a;
    o_alu_src_b  = w_ctrl.alu_src_b;
    o_alu_op     = w_ctrl.alu_op;
    o_pc_source  = w_ctrl.pc_source;
    o_illegal_op = r_illegal;
    o_state      = r_state;
    o_instr_cnt  = r_instr_cnt;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction state plans from the opcode table,
// random opcodes / memory waits / alu_zero, checked every cycle.
module tb_mips_multicycle_ctrl;

  logic        clk, rst_n;
  logic [5:0]  opcode;
  logic        alu_zero, mem_ready;
  logic        pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic        alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  int ncmp = 0;
  int nerr = 0;
  int model_cnt = 0;
  bit ill_pend = 0;

  mips_multicycle_ctrl #(.CNT_W(32), .STATE_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_alu_zero(alu_zero),
    .i_mem_ready(mem_ready), .o_pc_en(pc_en), .o_i_or_d(i_or_d),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_ir_write(ir_write),
    .o_mem_to_reg(mem_to_reg), .o_reg_dst(reg_dst), .o_reg_write(reg_write),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
    .o_pc_source(pc_source), .o_illegal_op(illegal_op), .o_state(state),
    .o_instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction class: 0 illegal, 1 R, 2 lw, 3 sw, 4 branch, 5 j, 6 addi
  function automatic int kind(input logic [5:0] op);
    case (op)
      6'b000000: return 1;
      6'b100011: return 2;
      6'b101011: return 3;
      6'b000100: return 4;
`ifdef MIPS_CTRL_BNE_EN
      6'b000101: return 4;
`endif
      6'b000010: return 5;
      6'b001000: return 6;
      default:   return 0;
    endcase
  endfunction

  // Select fields {i_or_d,mem_to_reg,reg_dst,src_a,src_b,alu_op,pc_source}; mask = specified bits
  task automatic sel_exp(input int st, output logic [9:0] e, output logic [9:0] m);
    case (st)
      0:       begin m = 10'b1001111111; e = 10'b0000010000; end
      1:       begin m = 10'b0001111100; e = 10'b0000110000; end
      2, 10:   begin m = 10'b0001111100; e = 10'b0001100000; end
      3, 5:    begin m = 10'b1000000000; e = 10'b1000000000; end
      4:       begin m = 10'b0110000000; e = 10'b0100000000; end
      6:       begin m = 10'b0001111100; e = 10'b0001001000; end
      7:       begin m = 10'b0110000000; e = 10'b0010000000; end
      8:       begin m = 10'b0001111111; e = 10'b0001000101; end
      9:       begin m = 10'b0000000011; e = 10'b0000000010; end
      default: begin m = 10'b0110000000; e = 10'b0000000000; end
    endcase
  endtask

  function automatic logic [9:0] sel_obs();
    return {i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1
  task automatic cycle(input int st, input logic rdy, input logic [5:0] op, input int zsel);
    logic z, taken, e_pc;
    logic [9:0] e, m;
    z = (zsel < 0) ? logic'($urandom_range(0, 1)) : logic'(zsel);
    opcode = op; mem_ready = rdy; alu_zero = z;
    @(negedge clk);
    taken = z;
`ifdef MIPS_CTRL_BNE_EN
    if (op == 6'b000101) taken = ~z;
`endif
    e_pc = (st == 0) ? rdy : (st == 8) ? taken : (st == 9);
    chk("state", 32'(state), 32'(st));
    chk("strobes", {26'd0, pc_en, mem_read, mem_write, ir_write, reg_write, illegal_op},
        {26'd0, e_pc, (st == 0 || st == 3), (st == 5), (st == 0 && rdy),
         (st == 4 || st == 7 || st == 11), ill_pend});
    sel_exp(st, e, m);
    chk("selects", 32'(sel_obs() & m), 32'(e));
    chk("instr_cnt", instr_cnt, 32'(model_cnt));
    ill_pend = 0;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int zsel);
    int plan[$];
    logic rdy[$];
    int k;
    k = kind(op);
    for (int i = 0; i < fw; i++) begin plan.push_back(0); rdy.push_back(1'b0); end
    plan.push_back(0); rdy.push_back(1'b1);
    plan.push_back(1); rdy.push_back(logic'($urandom_range(0, 1)));
    case (k)
      1: begin plan.push_back(6); plan.push_back(7); rdy.push_back(1'b1); rdy.push_back(1'b0); end
      2: begin
        plan.push_back(2); rdy.push_back(logic'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin plan.push_back(3); rdy.push_back(1'b0); end
        plan.push_back(3); rdy.push_back(1'b1);
        plan.push_back(4); rdy.push_back(logic'($urandom_range(0, 1)));
      end
      3: begin
        plan.push_back(2); rdy.push_back(logic'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin plan.push_back(5); rdy.push_back(1'b0); end
        plan.push_back(5); rdy.push_back(1'b1);
      end
      4: begin plan.push_back(8); rdy.push_back(logic'($urandom_range(0, 1))); end
      5: begin plan.push_back(9); rdy.push_back(logic'($urandom_range(0, 1))); end
      6: begin plan.push_back(10); plan.push_back(11); rdy.push_back(1'b0); rdy.push_back(1'b1); end
      default: ;
    endcase
    for (int i = 0; i < plan.size(); i++) cycle(plan[i], rdy[i], op, zsel);
    if (k == 0) ill_pend = 1;
    else        model_cnt++;
  endtask

  initial begin
    logic [5:0] ops[7];
    logic [5:0] op;
    logic [9:0] e, m;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b000101; ops[5] = 6'b000010; ops[6] = 6'b001000;

    rst_n = 1'b0; opcode = 6'b0; alu_zero = 1'b0; mem_ready = 1'b1;
    // Reset held two cycles: strobes forced off, selects at fetch values
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_strobes", {27'd0, pc_en, mem_read, mem_write, ir_write, reg_write}, 32'd0);
      sel_exp(0, e, m);
      chk("rst_selects", 32'(sel_obs() & m), 32'(e));
      if (i == 1) begin
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(6'b000000, 0, 0, -1);   // R-type, zero-wait
    run_instr(6'b100011, 0, 3, -1);   // lw, 3 wait cycles in MEM_READ
    run_instr(6'b000100, 1, 0, 1);    // beq taken
    run_instr(6'b000100, 0, 0, 0);    // beq not taken
    run_instr(6'b111111, 0, 0, -1);   // illegal
    run_instr(6'b001000, 0, 0, -1);   // addi, also checks the illegal pulse
    run_instr(6'b000101, 0, 0, 0);    // bne (legal only with the option)
    run_instr(6'b000010, 2, 0, -1);   // jump
    run_instr(6'b101011, 0, 2, -1);   // sw

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 7) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    // Reset in the middle of a stalled store
    cycle(0, 1'b1, 6'b101011, -1);
    cycle(1, 1'b0, 6'b101011, -1);
    cycle(2, 1'b0, 6'b101011, -1);
    cycle(5, 1'b0, 6'b101011, -1);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_state_hold", 32'(state), 32'd5);
    @(posedge clk); #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1;
    model_cnt = 0;
    ill_pend = 0;
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b000010, 0, 0, -1);
    cycle(0, 1'b0, 6'b000000, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
